// File: rtl/sipo_register.sv
// -----------------------------------------------------------------------------
// sipo_register
//
// Serial-in, parallel-out capture register. This is the receive end of the
// PISO shift register. A free-running clock divider produces clkOut and a
// one-cycle "tick" on each rising edge of clkOut. While a frame is being
// captured, one bit of bitIn is sampled per tick, LSB first. Each completed
// WIDTH-bit word is presented on regOut together with a one-cycle valid
// strobe.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   DIV_COUNT  clkIn cycles per clkOut half-period (bit period = 2*DIV_COUNT)
//
// Ports:
//   clkIn     in   system clock, all logic on its rising edge
//   rstN      in   asynchronous active-low reset
//   bitIn     in   serial data, LSB first
//   load      in   start-of-frame request, level sampled every clkIn cycle
//   clkOut    out  divided clock, toggles every DIV_COUNT cycles
//   regOut    out  last completed word (never shows a partial word)
//   valid     out  one-cycle pulse when regOut updates
//   busy      out  high while a frame is being captured
//   bitCount  out  bits captured so far in the current frame
//   overrun   out  sticky flag: load seen while busy (cleared by accepted load)
// -----------------------------------------------------------------------------
module sipo_register #(
   parameter int WIDTH     = 8,
   parameter int DIV_COUNT = 100000000
) (
   input  logic                       clkIn,
   input  logic                       rstN,
   input  logic                       bitIn,
   input  logic                       load,
   output logic                       clkOut,
   output logic [WIDTH-1:0]           regOut,
   output logic                       valid,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] bitCount,
   output logic                       overrun
);

   // Counter width; DIV_COUNT=1 still needs a one-bit counter.
   localparam int CW  = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam int BCW = $clog2(WIDTH+1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Divider state
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             clk_out_q, clk_out_d;

   // Capture state
   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] reg_out_q, reg_out_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   logic             term_cnt;
   logic             tick;
   logic             complete;
   logic [WIDTH-1:0] shifted;

   // -------------------------------------------------------------------------
   // Divider: free-running, independent of the capture state. A tick is the
   // terminal-count cycle on which clkOut is about to rise.
   // -------------------------------------------------------------------------
   always_comb begin
      term_cnt  = (cnt_q == CW'(DIV_COUNT - 1));
      cnt_d     = term_cnt ? '0 : cnt_q + 1'b1;
      clk_out_d = clk_out_q ^ term_cnt;
      tick      = term_cnt & ~clk_out_q;
   end

   // -------------------------------------------------------------------------
   // Capture next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      reg_out_d = reg_out_q;
      valid_d   = 1'b0;
      overrun_d = overrun_q;

      shifted   = {bitIn, shift_q[WIDTH-1:1]};
      // The tick that samples bit WIDTH-1 finishes the word.
      complete  = (state_q == ST_SHIFT) && tick &&
                  (bit_cnt_q == BCW'(WIDTH - 1));

      unique case (state_q)
         ST_IDLE: begin
            // A load on a tick cycle does not sample; first sample is next tick.
            if (load) begin
               state_d   = ST_SHIFT;
               shift_d   = '0;
               bit_cnt_d = '0;
               overrun_d = 1'b0;
            end
         end

         ST_SHIFT: begin
            if (tick) begin
               shift_d   = shifted;
               bit_cnt_d = bit_cnt_q + 1'b1;
            end

            if (complete) begin
               reg_out_d = shifted;
               valid_d   = 1'b1;
               bit_cnt_d = '0;
               state_d   = ST_IDLE;
               // Load in the completion cycle starts the next frame right away.
               if (load) begin
                  state_d   = ST_SHIFT;
                  shift_d   = '0;
                  overrun_d = 1'b0;
               end
            end else if (load) begin
               // Mid-frame load is ignored for data but remembered.
               overrun_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clkIn or negedge rstN) begin
      if (!rstN) begin
         cnt_q     <= '0;
         clk_out_q <= 1'b0;
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         reg_out_q <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         reg_out_q <= reg_out_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign clkOut   = clk_out_q;
   assign regOut   = reg_out_q;
   assign valid    = valid_q;
   assign busy     = (state_q == ST_SHIFT);
   assign bitCount = bit_cnt_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_sipo_register.sv
// -----------------------------------------------------------------------------
// tb_sipo_register
//
// Directed bench for sipo_register with WIDTH=8, DIV_COUNT=2 (tick every 4
// cycles). Frames are described in a vector table and replayed in a loop;
// reset behaviour is exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_sipo_register;

   localparam int WIDTH = 8;
   localparam int DIV   = 2;
   localparam int BCW   = $clog2(WIDTH+1);

   logic             clk;
   logic             rst_n;
   logic             bit_in;
   logic             load;
   logic             clk_out;
   logic [WIDTH-1:0] reg_out;
   logic             valid;
   logic             busy;
   logic [BCW-1:0]   bit_count;
   logic             overrun;

   int n_cmp  = 0;
   int n_fail = 0;

   // Bench-side model of the divider: number of rising edges since reset
   // release. Edge k is a tick when k % 4 == 2.
   int edge_n;

   logic [WIDTH-1:0] exp_reg;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               ovr_at;   // bits captured before a stray load; -1 none
      bit               b2b;      // load asserted on the completion cycle
   } vec_t;

   vec_t vecs[5];

   sipo_register #(
      .WIDTH    (WIDTH),
      .DIV_COUNT(DIV)
   ) dut (
      .clkIn   (clk),
      .rstN    (rst_n),
      .bitIn   (bit_in),
      .load    (load),
      .clkOut  (clk_out),
      .regOut  (reg_out),
      .valid   (valid),
      .busy    (busy),
      .bitCount(bit_count),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Advance until the next rising edge is a tick edge.
   task automatic to_tick();
      for (int n = 0; n < 8; n++) begin
         if (((edge_n + 1) % (2*DIV)) == DIV) return;
         cyc();
      end
      chk("to_tick_bound", 32'd0, 32'd1);
   endtask

   task automatic start_load();
      load = 1'b1;
      cyc();
      load = 1'b0;
      chk("load_busy", busy, 1);
      chk("load_bitcount", bit_count, 0);
      chk("load_overrun", overrun, 0);
      chk("load_valid", valid, 0);
   endtask

   // Send nbits of data, LSB first, one per tick; checks every tick.
   task automatic shift_bits(input logic [WIDTH-1:0] data, input int nbits,
                             input int ovr_at, input bit b2b);
      for (int i = 0; i < nbits; i++) begin
         to_tick();
         bit_in = data[i];
         if (i == WIDTH-1 && b2b) load = 1'b1;
         cyc();
         load = 1'b0;
         if (i < WIDTH-1) begin
            chk($sformatf("bitcount_%0d", i), bit_count, i+1);
            chk($sformatf("hold_reg_%0d", i), reg_out, exp_reg);
            chk($sformatf("no_valid_%0d", i), valid, 0);
            chk($sformatf("busy_%0d", i), busy, 1);
            if (i + 1 == ovr_at) begin
               load = 1'b1;
               cyc();
               load = 1'b0;
               chk("overrun_set", overrun, 1);
               chk("overrun_busy", busy, 1);
            end
         end else begin
            exp_reg = data;
            chk("done_reg", reg_out, data);
            chk("done_valid", valid, 1);
            chk("done_bitcount", bit_count, 0);
            chk("done_busy", busy, b2b);
            cyc();
            chk("post_valid", valid, 0);
            chk("post_busy", busy, b2b);
            chk("post_bitcount", bit_count, 0);
            chk("post_reg", reg_out, data);
         end
      end
   endtask

   initial begin
      vecs[0] = '{data: 8'hA5, ovr_at: -1, b2b: 1'b0};
      vecs[1] = '{data: 8'hA5, ovr_at:  3, b2b: 1'b0};
      vecs[2] = '{data: 8'hA5, ovr_at: -1, b2b: 1'b1};
      vecs[3] = '{data: 8'h3C, ovr_at: -1, b2b: 1'b0};
      vecs[4] = '{data: 8'h5A, ovr_at:  6, b2b: 1'b0};

      rst_n   = 1'b0;
      load    = 1'b0;
      bit_in  = 1'b0;
      exp_reg = '0;

      // Reset values
      #2;
      chk("rst_clkout", clk_out, 0);
      chk("rst_reg", reg_out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bitcount", bit_count, 0);
      chk("rst_overrun", overrun, 0);

      @(negedge clk);
      cyc();
      rst_n = 1'b1;

      // Divider: after edge k, clkOut = (k/2) % 2
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk($sformatf("clkout_e%0d", edge_n), clk_out, (edge_n / DIV) % 2);
      end

      // Table-driven frames
      for (int v = 0; v < 5; v++) begin
         if (v == 0 || !vecs[v-1].b2b) start_load();
         chk("pre_bitcount", bit_count, 0);
         shift_bits(vecs[v].data, WIDTH, vecs[v].ovr_at, vecs[v].b2b);
         chk($sformatf("frame%0d_overrun", v), overrun, vecs[v].ovr_at >= 0);
         $display("frame %0d: data 0x%02h regOut 0x%02h overrun %0b",
                  v, vecs[v].data, reg_out, overrun);
      end

      // Reset mid-frame: 4 bits of 0xC3, then asynchronous reset
      start_load();
      shift_bits(8'hC3, 4, -1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_reg", reg_out, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_bitcount", bit_count, 0);
      chk("async_rst_clkout", clk_out, 0);
      chk("async_rst_valid", valid, 0);
      chk("async_rst_overrun", overrun, 0);
      @(negedge clk);
      cyc();
      chk("in_rst_reg", reg_out, 0);
      chk("in_rst_valid", valid, 0);
      rst_n   = 1'b1;
      exp_reg = '0;

      start_load();
      shift_bits(8'hFF, WIDTH, -1, 1'b0);
      chk("after_rst_overrun", overrun, 0);
      $display("frame after reset: regOut 0x%02h", reg_out);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sipo_register.md
Name: sipo_register

Overview:
- Serial-in, parallel-out capture register. It is the receive end of the team's PISO shift register.
- Samples `bitIn` once per divided-clock period, LSB first, and assembles WIDTH bits.
- Presents each completed word on `regOut` with a one-cycle `valid` strobe.
- Contains the same free-running clock divider as the transmit side, so both ends run at the same bit rate.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- DIV_COUNT, 100000000, number of `clkIn` cycles per `clkOut` half-period. One bit period is 2*DIV_COUNT cycles.

Ports:
- clkIn  input  1  system clock; all logic is on its rising edge.
- rstN  input  1  asynchronous, active-low reset.
- bitIn  input  1  serial data, LSB first.
- load  input  1  start-of-frame request; level sampled each `clkIn` cycle.
- clkOut  output  1  divided clock; toggles every DIV_COUNT cycles.
- regOut  output  WIDTH  last completed word.
- valid  output  1  one-cycle pulse when `regOut` updates.
- busy  output  1  high while a frame is being captured.
- bitCount  output  $clog2(WIDTH+1)  bits captured in the current frame.
- overrun  output  1  sticky: a `load` arrived while busy.

Behaviour:
- Reset (`rstN`=0, asynchronous):
  - Divider counter=0, `clkOut`=0, state=IDLE.
  - Shift register=0, `regOut`=0, `valid`=0, `busy`=0, `bitCount`=0, `overrun`=0.
  - Reset mid-frame discards the partial word. `regOut` is also cleared.
- Divider:
  - Counter runs 0..DIV_COUNT-1 from reset, independent of state.
  - At terminal count: counter goes to 0 and `clkOut` toggles.
  - tick = terminal-count cycle where `clkOut` is currently 0, i.e. the cycle on which `clkOut` rises. One tick per 2*DIV_COUNT cycles.
- State IDLE (`busy`=0):
  - `load`=1 → go to SHIFT. Clear the shift register, set `bitCount`=0, clear `overrun`.
  - A load accepted on a tick cycle does not sample on that cycle. The first sample is at the next tick.
- State SHIFT (`busy`=1), on each tick:
  - Shift register ← {bitIn, shiftReg[WIDTH-1:1]}; `bitCount` increments.
  - The tick that captures bit WIDTH-1 is the completion tick. On it:
    - `regOut` ← the new shift-register value (the word including that bit).
    - `valid`=1 for that cycle only.
    - `bitCount` returns to 0 and the state goes to IDLE.
  - Non-tick cycles hold all state.
- Back-to-back frames: `load`=1 in the completion cycle is accepted as the next frame start. The next cycle is SHIFT with a cleared shift register and `bitCount`=0, and no overrun is flagged.
- `load`=1 in SHIFT on any cycle other than completion is ignored for data. It sets `overrun`=1, which holds until the next accepted load or reset.
- `regOut` holds its value between completions. It never shows partial words.
- `valid` is registered. It is never high while `rstN`=0.

Test Plan:
All scenarios use DIV_COUNT=2 (tick every 4 cycles) and WIDTH=8.
- Reset: drive `rstN`=0 mid-operation → all outputs 0 immediately, asynchronously, without a clock edge. Release reset → `clkOut` toggles every 2 cycles, period 4.
- Single frame: pulse `load`, then present bits 1,0,1,0,0,1,0,1, one per tick → on the 8th tick `regOut`=0xA5 and `valid` is high for exactly 1 cycle. Next cycle `busy`=0 and `bitCount`=0.
- Bit counting: during that frame → `bitCount` steps 0→7 on successive ticks, then returns to 0 on the completion tick. `regOut` stays 0 until completion.
- Overrun: assert `load` after 3 bits of frame 0xA5 → `overrun`=1, and the frame still completes with 0xA5. A new `load` in IDLE clears `overrun` to 0.
- Back-to-back: hold `load`=1 through the completion cycle of 0xA5, then send 0x3C (bits 0,0,1,1,1,1,0,0) → `regOut` holds 0xA5 until the second completion, then shows 0x3C. `overrun` stays 0.
- Reset mid-frame: assert `rstN`=0 after 4 bits, release it, load, and send 0xFF → `regOut` reads 0x00 during the reset, then 0xFF after 8 new ticks, with no residue from the aborted frame.
